uart_tx_cfg: RTL and testbench

Parametrised successor to the fixed 8N1 UART transmitter. It serialises words of DATA_BITS (5..9) LSB-first, with a runtime-selectable parity mode and stop-bit count. Input uses a ready/valid handshake. It drops into the same place as the existing transmitter and feeds the RX line directly or through the active-gated line mux.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_tx_fifo.sv | 52 +++++
 rtl/uart_tx_cfg.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART transmitter.
// Parity modes, FSM encoding and frame-length helper.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  typedef struct packed {
    logic par_en;
    logic two_stop;
  } tx_cfg_t;

  function automatic int frame_clks(
    input int   cpb,
    input int   db,
    input logic par_en,
    input logic two_stop
  );
    return cpb * (1 + db + (par_en ? 1 : 0)
                  + (two_stop ? 2 : 1));
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO feeding the transmitter FSM.
// DEPTH must be a power of two so the pointers wrap for free.
module uart_tx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: 5..9 data bits, parity, 1/2 stop.
// Define UART_TX_FIFO_EN to place an input FIFO in front of the FSM.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_L,
  input  logic                 i_TX_DV,
  input  logic [DATA_BITS-1:0] i_TX_Byte,
  output logic                 o_TX_Ready,
  input  logic [1:0]           i_Parity_Mode,
  input  logic                 i_Two_Stop,
  output logic                 o_TX_Active,
  output logic                 o_TX_Serial,
  output logic                 o_TX_Done
);

  if (DATA_BITS < 5 || DATA_BITS > 9 || CLKS_PER_BIT < 2)
  begin : g_bad_cfg
    $error("uart_tx_cfg: illegal DATA_BITS/CLKS_PER_BIT");
  end

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH-1)) != 0)
  begin : g_bad_depth
    $error("uart_tx_cfg: FIFO_DEPTH must be 2^n >= 2");
  end

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS+1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT-1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT-2);
  localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_BITS-1);

  tx_state_t            state;
  tx_state_t            state_nx;
  logic [BW-1:0]        baud;
  logic [IW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  tx_cfg_t              cfg_q;
  logic                 par_q;
  logic                 done_q;

  logic                 idle;
  logic                 accept;
  logic                 baud_wrap;
  logic                 stop_last;
  logic [DATA_BITS-1:0] src_word;
  logic [1:0]           src_mode;
  logic                 src_two;

  assign idle      = (state == ST_IDLE);
  assign baud_wrap = (baud == BAUD_LAST);
  assign stop_last = (bit_cnt == IW'(cfg_q.two_stop));

`ifdef UART_TX_FIFO_EN
  logic fifo_full;
  logic fifo_empty;

  uart_tx_fifo #(
    .W     (DATA_BITS + 3),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_Clock),
    .rst_n (i_Rst_L),
    .push  (i_TX_DV),
    .wdata ({i_Two_Stop, i_Parity_Mode, i_TX_Byte}),
    .pop   (accept),
    .rdata ({src_two, src_mode, src_word}),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign accept     = idle & ~fifo_empty;
  assign o_TX_Ready = ~fifo_full;
`else
  assign accept     = idle & i_TX_DV;
  assign o_TX_Ready = idle;
  assign src_word   = i_TX_Byte;
  assign src_mode   = i_Parity_Mode;
  assign src_two    = i_Two_Stop;
`endif

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) state <= ST_IDLE;
    else          state <= state_nx;
  end

  // The last stop clock is spent in IDLE so a new start can follow at once.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:   if (accept) state_nx = ST_START;
      ST_START:  if (baud_wrap) state_nx = ST_DATA;
      ST_DATA:
        if (baud_wrap && bit_cnt == BIT_LAST)
          state_nx = cfg_q.par_en ? ST_PARITY : ST_STOP;
      ST_PARITY: if (baud_wrap) state_nx = ST_STOP;
      ST_STOP:
        if (stop_last && baud == BAUD_PRE)
          state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      baud    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      cfg_q   <= '0;
      par_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state == ST_STOP) && (state_nx == ST_IDLE);
      if (accept) begin
        shreg          <= src_word;
        cfg_q.par_en   <= (src_mode == PAR_EVEN) ||
                          (src_mode == PAR_ODD);
        cfg_q.two_stop <= src_two;
        par_q          <= (^src_word) ^ (src_mode == PAR_ODD);
        baud           <= '0;
        bit_cnt        <= '0;
      end else if (!idle) begin
        if (baud_wrap || state_nx != state) baud <= '0;
        else                                baud <= baud + 1'b1;
        if (baud_wrap && state == ST_DATA) begin
          shreg   <= shreg >> 1;
          bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
        end
        if (baud_wrap && state == ST_STOP)
          bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    o_TX_Serial = 1'b1;
    o_TX_Active = 1'b0;
    unique case (state)
      ST_START: begin
        o_TX_Serial = 1'b0;
        o_TX_Active = 1'b1;
      end
      ST_DATA: begin
        o_TX_Serial = shreg[0];
        o_TX_Active = 1'b1;
      end
      ST_PARITY: begin
        o_TX_Serial = par_q;
        o_TX_Active = 1'b1;
      end
      ST_STOP:   o_TX_Active = 1'b1;
      default: begin
        o_TX_Serial = 1'b1;
        o_TX_Active = 1'b0;
      end
    endcase
  end

  assign o_TX_Done = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg (8-bit/217 and 5-bit/4 instances).
// FIFO scenario runs when UART_TX_FIFO_EN is defined.
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dv8, dv5, two;
  logic [1:0] mode;
  logic [7:0] byte8;
  logic [4:0] byte5;
  logic       rdy8, act8, ser8, done8;
  logic       rdy5, act5, ser5, done5;
  logic       sel;
  logic       ser, act, done, rdy;
  int         total = 0;
  int         passes = 0;

  always #5 clk = ~clk;

  assign ser  = sel ? ser5 : ser8;
  assign act  = sel ? act5 : act8;
  assign done = sel ? done5 : done8;
  assign rdy  = sel ? rdy5 : rdy8;

  uart_tx_cfg #(
    .CLKS_PER_BIT (217),
    .DATA_BITS    (8),
    .FIFO_DEPTH   (4)
  ) u8 (
    .i_Clock       (clk),
    .i_Rst_L       (rst_n),
    .i_TX_DV       (dv8),
    .i_TX_Byte     (byte8),
    .o_TX_Ready    (rdy8),
    .i_Parity_Mode (mode),
    .i_Two_Stop    (two),
    .o_TX_Active   (act8),
    .o_TX_Serial   (ser8),
    .o_TX_Done     (done8)
  );

  uart_tx_cfg #(
    .CLKS_PER_BIT (4),
    .DATA_BITS    (5),
    .FIFO_DEPTH   (4)
  ) u5 (
    .i_Clock       (clk),
    .i_Rst_L       (rst_n),
    .i_TX_DV       (dv5),
    .i_TX_Byte     (byte5),
    .o_TX_Ready    (rdy5),
    .i_Parity_Mode (mode),
    .i_Two_Stop    (two),
    .o_TX_Active   (act5),
    .o_TX_Serial   (ser5),
    .o_TX_Done     (done5)
  );

  // Called on the negedge of the first start-bit clock; returns on
  // the negedge of the Done clock (last stop clock).
  task automatic check_frame(
    input  string       name,
    input  int          nb,
    input  logic [15:0] bits,
    input  int          inj_c,
    input  logic [7:0]  inj_w,
    input  logic [1:0]  inj_m,
    output logic [15:0] cap
  );
    int   cpb, len, bad_c, bad_d;
    logic bad_v;
    cpb   = sel ? 4 : 217;
    len   = nb * cpb;
    bad_c = -1;
    bad_d = -1;
    bad_v = 1'b0;
    cap   = '0;
    for (int c = 0; c < len; c++) begin
      if (c == inj_c) begin
        if (sel) begin
          dv5 = 1'b1; byte5 = inj_w[4:0];
        end else begin
          dv8 = 1'b1; byte8 = inj_w;
        end
        mode = inj_m;
      end
      if (inj_c >= 0 && c == inj_c + 1) begin
        dv5 = 1'b0; dv8 = 1'b0;
      end
      if (c % cpb == cpb / 2) cap[c/cpb] = ser;
      if (bad_c < 0 && ser !== bits[c/cpb]) begin
        bad_c = c; bad_v = ser;
      end
      if (bad_d < 0 && (done !== (c == len-1) ||
                        act !== (c != len-1)))
        bad_d = c;
      if (c < len - 1) @(negedge clk);
    end
    total++;
    if (bad_c >= 0)
      $display("FAIL %s line: cycle %0d got %b want %b",
               name, bad_c, bad_v, bits[bad_c/cpb]);
    else passes++;
    total++;
    if (bad_d >= 0)
      $display("FAIL %s done/active: wrong at cycle %0d, want done only at %0d",
               name, bad_d, len-1);
    else passes++;
  endtask

  task automatic start8(input logic [7:0] w,
                        input logic [1:0] m,
                        input logic t);
    dv8 = 1'b1; byte8 = w; mode = m; two = t;
    @(negedge clk);
    dv8 = 1'b0;
`ifdef UART_TX_FIFO_EN
    @(negedge clk);
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({ser8, act8, done8, rdy8} !== 4'b1001)
      $display("FAIL reset8: ser/act/done/rdy got %b want 1001",
               {ser8, act8, done8, rdy8});
    else passes++;
    total++;
    if ({ser5, act5, done5, rdy5} !== 4'b1001)
      $display("FAIL reset5: ser/act/done/rdy got %b want 1001",
               {ser5, act5, done5, rdy5});
    else passes++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_even_f4();
    logic [15:0] cap;
    sel = 1'b0;
    start8(8'hF4, 2'b01, 1'b0);
    check_frame("even_f4", 11, {5'b0, 1'b1, 1'b1, 8'hF4, 1'b0},
                -1, 8'h00, 2'b01, cap);
    total++;
    if (cap[8:1] !== 8'hF4)
      $display("FAIL rx_f4: got %h want f4", cap[8:1]);
    else passes++;
    total++;
    if (cap[9] !== 1'b1)
      $display("FAIL parity_even_f4: got %b want 1", cap[9]);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_odd_two_stop();
    logic [15:0] cap;
    sel = 1'b0;
    start8(8'h00, 2'b10, 1'b1);
    check_frame("odd2_00", 12, {4'b0, 3'b111, 8'h00, 1'b0},
                -1, 8'h00, 2'b10, cap);
    total++;
    if (cap[9] !== 1'b1)
      $display("FAIL parity_odd_00: got %b want 1", cap[9]);
    else passes++;
    two = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ignore_mid();
    logic [15:0] cap;
    sel = 1'b0;
    start8(8'hA5, 2'b01, 1'b0);
    check_frame("ignore_a5", 11, {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0},
                500, 8'h3C, 2'b10, cap);
    @(negedge clk);
    total++;
    if ({ser8, act8} !== 2'b10)
      $display("FAIL dropped_word: ser/act got %b want 10",
               {ser8, act8});
    else passes++;
    mode = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [15:0] cap;
    sel = 1'b1;
    mode = 2'b00; two = 1'b0;
    dv5 = 1'b1; byte5 = 5'h1F;
    @(negedge clk);
    dv5 = 1'b0;
`ifdef UART_TX_FIFO_EN
    @(negedge clk);
    check_frame("b2b_1f", 7, {9'b0, 1'b1, 5'h1F, 1'b0},
                2, 8'h0A, 2'b00, cap);
    @(negedge clk);
`else
    check_frame("b2b_1f", 7, {9'b0, 1'b1, 5'h1F, 1'b0},
                -1, 8'h00, 2'b00, cap);
    dv5 = 1'b1; byte5 = 5'h0A;
    @(negedge clk);
    dv5 = 1'b0;
`endif
    check_frame("b2b_0a", 7, {9'b0, 1'b1, 5'h0A, 1'b0},
                -1, 8'h00, 2'b00, cap);
    total++;
    if (cap[5:1] !== 5'h0A)
      $display("FAIL rx_0a: got %h want 0a", cap[5:1]);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [15:0] cap;
    int          bad;
    sel = 1'b0;
    start8(8'h55, 2'b00, 1'b0);
    repeat (4 * 217 + 100) @(negedge clk);
    total++;
    if (act8 !== 1'b1)
      $display("FAIL active_bit3: got %b want 1", act8);
    else passes++;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if ({ser8, act8, done8} !== 3'b100)
      $display("FAIL reset_mid: ser/act/done got %b want 100",
               {ser8, act8, done8});
    else passes++;
    bad = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ({ser8, act8, done8} !== 3'b100) bad++;
    end
    total++;
    if (bad != 0)
      $display("FAIL post_reset_quiet: %0d bad cycles want 0", bad);
    else passes++;
    start8(8'hC3, 2'b00, 1'b0);
    check_frame("after_rst_c3", 10, {6'b0, 1'b1, 8'hC3, 1'b0},
                -1, 8'h00, 2'b00, cap);
    @(negedge clk);
  endtask

`ifdef UART_TX_FIFO_EN
  task automatic test_fifo();
    logic [4:0] w [5];
    w = '{5'h01, 5'h12, 5'h0C, 5'h1E, 5'h15};
    sel = 1'b1; mode = 2'b00; two = 1'b0;
    fork
      begin
        int   i;
        logic acc;
        i = 0;
        for (int k = 0; k < 40 && i < 5; k++) begin
          dv5 = 1'b1; byte5 = w[i]; acc = rdy5;
          @(negedge clk);
          if (acc) i++;
        end
        dv5 = 1'b0;
        total++;
        if (i != 5)
          $display("FAIL fifo_accepts: got %0d want 5", i);
        else passes++;
        total++;
        if (rdy5 !== 1'b0)
          $display("FAIL fifo_full_ready: got %b want 0", rdy5);
        else passes++;
      end
      begin
        logic [15:0] cap;
        repeat (2) @(negedge clk);
        for (int f = 0; f < 5; f++) begin
          check_frame($sformatf("fifo_w%0d", f), 7,
                      {9'b0, 1'b1, w[f], 1'b0},
                      -1, 8'h00, 2'b00, cap);
          if (f < 4) @(negedge clk);
        end
      end
    join
    @(negedge clk);
  endtask
`endif

  initial begin
    rst_n = 1'b0; dv8 = 1'b0; dv5 = 1'b0; two = 1'b0;
    mode = 2'b00; byte8 = '0; byte5 = '0; sel = 1'b0;
    @(negedge clk);
    test_reset();
    test_even_f4();
    test_odd_two_stop();
`ifndef UART_TX_FIFO_EN
    test_ignore_mid();
`endif
    test_back_to_back();
    test_reset_mid();
`ifdef UART_TX_FIFO_EN
    test_fifo();
`endif
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
